alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width.
REQ-002 The block SHALL have parameter CTRL_W, default 4, meaning ALUControl width.
Ports:
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk, in, 1, rising-edge clock; reset, in, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ReqValid, in, 2, per-requester request valid (bit i = requester i).
REQ-005 The block SHALL have ReqReady, out, 2, per-requester request accepted this cycle.
REQ-006 The block SHALL have ReqSrcA0/ReqSrcA1, in, WIDTH, operand A of requester 0/1.
REQ-007 The block SHALL have ReqSrcB0/ReqSrcB1, in, WIDTH, operand B of requester 0/1.
REQ-008 The block SHALL have ReqCtrl0/ReqCtrl1, in, CTRL_W, ALU op of requester 0/1.
REQ-009 The block SHALL have AluSrcA, AluSrcB, out, WIDTH, and AluControl, out, CTRL_W, all driving the shared ALU.
REQ-010 The block SHALL have AluResult, in, WIDTH, combinational result from the shared ALU.
REQ-011 The block SHALL have RspValid, out, 2, response valid to requester i.
REQ-012 The block SHALL have RspReady, in, 2, requester i consumes its response.
REQ-013 The block SHALL have RspData, out, WIDTH, registered ALU result.
REQ-014 The block SHALL have RspErr, out, 1, the op held in RspData was unsupported.

Function
REQ-015 The FSM SHALL have states IDLE and RESP.
REQ-016 In IDLE with any ReqValid set, the block SHALL grant exactly one requester, drive its operands and op onto AluSrcA/AluSrcB/AluControl, and assert ReqReady for that requester only, all in the same cycle.
REQ-017 At the clock edge ending a grant cycle, the block SHALL capture AluResult into RspData, record the granted id, set RspErr, and go to RESP.
REQ-018 Latency SHALL be one cycle: a request accepted in cycle N produces RspValid[id]=1 in cycle N+1.
REQ-019 In RESP, RspValid[id] SHALL stay 1 and RspData/RspErr SHALL stay stable until RspReady[id]=1; RspReady of the other bit SHALL be ignored.
REQ-020 On RspReady[id] in RESP, the block SHALL return to IDLE; no grant SHALL occur in that same cycle (peak throughput 1 op per 2 cycles).
REQ-021 ReqReady SHALL be 0 in RESP; a pending ReqValid SHALL wait without loss.
REQ-022 When no grant occurs, AluSrcA, AluSrcB and AluControl SHALL be driven to 0.
REQ-023 With both ReqValid set, the grant SHALL go to the requester not granted last (round-robin); a single valid requester SHALL always win.
REQ-024 RspErr SHALL be 1 iff the captured op is not in {0000 ADD, 0001 SUB, 0011 OR, 0110 LUI}; the captured result SHALL be stored unchanged either way (e.g. 32'h0000AAAA).

Reset
REQ-025 Asserting reset SHALL immediately force state IDLE, RspValid=0, ReqReady=0, RspData=0, RspErr=0, last-grant pointer=1 (requester 0 wins the first tie), and ALU outputs to 0.
REQ-026 Reset asserted while in RESP SHALL discard the pending response; the requester SHALL NOT see RspValid after reset is released.

Configuration
REQ-027 With macro ALU_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties, and the round-robin pointer SHALL NOT be built; without the macro, REQ-023 round-robin SHALL apply.

Structure
REQ-028 Package alu_arb_pkg SHALL hold the ALU op encodings (ADD, SUB, OR, LUI), the FSM state type and the requester count constant (2).
REQ-029 Grant selection SHALL be one sub-module, alu_arb_pick, taking ReqValid and the last-grant pointer and returning a one-hot grant.

Verification
REQ-030 Single request: ReqValid=01, A=5, B=3, Ctrl=0001 -> ReqReady=01 in the same cycle; next cycle RspValid=01, RspData=2, RspErr=0.
REQ-031 Tie after reset: ReqValid=11 held, RspReady=11 on each response -> grants 0,1,0,1; each ReqReady is one-hot.
REQ-032 Backpressure: response pending with RspReady=00 for 5 cycles, new ReqValid=10 -> RspData stable, ReqReady=00 until accept; the next grant occurs one cycle after return to IDLE.
REQ-033 Bad op: Ctrl=0101 -> RspErr=1, RspData=32'h0000AAAA; LUI B=32'h00001234 -> RspData=32'h12340000, RspErr=0.
REQ-034 Reset in RESP: reset pulsed mid-response -> RspValid=00 at once and stays 00 after release; a subsequent tie is granted to requester 0.
REQ-035 ALU_ARB_FIXED_PRIO_EN defined: ReqValid=11 held for 4 ops -> all 4 grants go to requester 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: ALU op encodings, FSM state type and requester count
// shared by the ALU arbiter and its grant picker.
package alu_arb_pkg;

    localparam int NREQ = 2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_LUI = 4'b0110;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: two-requester grant selection.
// Ports: valid (request bits), last (id granted last), grant (one-hot).
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic [NREQ-1:0] valid,
    input  logic            last,
    output logic [NREQ-1:0] grant
);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters,
// one op per two cycles, registered response held until consumed.
// Ports: clk, reset (async, active high); ReqValid/ReqReady,
// ReqSrcA0/1, ReqSrcB0/1, ReqCtrl0/1 (requests); AluSrcA/AluSrcB/
// AluControl, AluResult (shared ALU); RspValid/RspReady, RspData,
// RspErr (responses).
// Macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties and no
// round-robin pointer is built.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   ReqValid,
    output logic [NREQ-1:0]   ReqReady,
    input  logic [WIDTH-1:0]  ReqSrcA0,
    input  logic [WIDTH-1:0]  ReqSrcA1,
    input  logic [WIDTH-1:0]  ReqSrcB0,
    input  logic [WIDTH-1:0]  ReqSrcB1,
    input  logic [CTRL_W-1:0] ReqCtrl0,
    input  logic [CTRL_W-1:0] ReqCtrl1,
    output logic [WIDTH-1:0]  AluSrcA,
    output logic [WIDTH-1:0]  AluSrcB,
    output logic [CTRL_W-1:0] AluControl,
    input  logic [WIDTH-1:0]  AluResult,
    output logic [NREQ-1:0]   RspValid,
    input  logic [NREQ-1:0]   RspReady,
    output logic [WIDTH-1:0]  RspData,
    output logic              RspErr
);

    state_t          state;
    logic            pick_last;
    logic [NREQ-1:0] pick_grant;
    logic [NREQ-1:0] grant;
    logic            op_bad;
    logic            rsp_take;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Pinning "last" to 1 makes requester 0 the tie winner.
    assign pick_last = 1'b1;
`else
    logic last;
    assign pick_last = last;
`endif

    alu_arb_pick u_pick (
        .valid (ReqValid),
        .last  (pick_last),
        .grant (pick_grant)
    );

    // Reset gates the grant so ALU outputs drop immediately.
    assign grant    = (state == IDLE && !reset) ? pick_grant : '0;
    assign ReqReady = grant;

    always_comb begin
        AluSrcA    = '0;
        AluSrcB    = '0;
        AluControl = '0;
        unique case (1'b1)
            grant[0]: begin
                AluSrcA    = ReqSrcA0;
                AluSrcB    = ReqSrcB0;
                AluControl = ReqCtrl0;
            end
            grant[1]: begin
                AluSrcA    = ReqSrcA1;
                AluSrcB    = ReqSrcB1;
                AluControl = ReqCtrl1;
            end
            default: ;
        endcase
    end

    assign op_bad = !((AluControl == CTRL_W'(OP_ADD)) ||
                      (AluControl == CTRL_W'(OP_SUB)) ||
                      (AluControl == CTRL_W'(OP_OR))  ||
                      (AluControl == CTRL_W'(OP_LUI)));

    // RspValid is one-hot and doubles as the granted id, so only the
    // owner's RspReady bit can release the response.
    assign rsp_take = |(RspValid & RspReady);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            RspValid <= '0;
            RspData  <= '0;
            RspErr   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last     <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|grant) begin
                        RspData  <= AluResult;
                        RspErr   <= op_bad;
                        RspValid <= grant;
                        state    <= RESP;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last     <= grant[1];
`endif
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        RspValid <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a
// behavioural ALU and a response scoreboard.
module tb_alu_arbiter;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ReqValid;
    logic [1:0]  ReqReady;
    logic [31:0] a0, a1, b0, b1;
    logic [3:0]  c0, c1;
    logic [31:0] AluSrcA, AluSrcB, AluResult;
    logic [3:0]  AluControl;
    logic [1:0]  RspValid;
    logic [1:0]  RspReady;
    logic [31:0] RspData;
    logic        RspErr;

    int   tests = 0;
    int   fails = 0;
    logic tb_last;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqSrcA0   (a0),
        .ReqSrcA1   (a1),
        .ReqSrcB0   (b0),
        .ReqSrcB1   (b1),
        .ReqCtrl0   (c0),
        .ReqCtrl1   (c1),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .AluControl (AluControl),
        .AluResult  (AluResult),
        .RspValid   (RspValid),
        .RspReady   (RspReady),
        .RspData    (RspData),
        .RspErr     (RspErr)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0011: return a | b;
            4'b0110: return {b[15:0], 16'h0000};
            default: return 32'h0000AAAA;
        endcase
    endfunction

    function automatic logic bad_op(input logic [3:0] op);
        return !(op == 4'b0000 || op == 4'b0001 ||
                 op == 4'b0011 || op == 4'b0110);
    endfunction

    function automatic logic [1:0] exp_pick(input logic [1:0] v,
                                            input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    always_comb AluResult = alu_fn(AluControl, AluSrcA, AluSrcB);

    task automatic run_op(input logic [1:0] v, input logic [1:0] vhold,
                          input int stall);
        logic [1:0]  g;
        logic [31:0] ea, eb;
        logic [3:0]  ec;
        exp_t        e;
        ReqValid = v;
        RspReady = 2'b00;
        g = exp_pick(v, tb_last);
        ea = 0; eb = 0; ec = 0;
        if (g == 2'b01) begin ea = a0; eb = b0; ec = c0; end
        if (g == 2'b10) begin ea = a1; eb = b1; ec = c1; end
        @(negedge clk);
        tests++;
        if (ReqReady !== g) begin
            fails++;
            $display("FAIL grant: ReqReady=%b expected %b", ReqReady, g);
        end
        tests++;
        if (AluSrcA !== ea || AluSrcB !== eb || AluControl !== ec) begin
            fails++;
            $display("FAIL alu_drive: A=%h B=%h C=%h expected %h %h %h",
                     AluSrcA, AluSrcB, AluControl, ea, eb, ec);
        end
        if (g != 2'b00) begin
            e.id = g; e.data = alu_fn(ec, ea, eb); e.err = bad_op(ec);
            sb.push_back(e);
`ifndef ALU_ARB_FIXED_PRIO_EN
            tb_last = g[1];
`endif
        end
        @(posedge clk); #1;
        ReqValid = vhold;
        if (g == 2'b00) return;
        for (int i = 0; i < stall; i++) begin
            RspReady = ~g;
            @(negedge clk);
            tests++;
            if (RspValid !== g || ReqReady !== 2'b00 ||
                RspData !== sb[0].data) begin
                fails++;
                $display("FAIL hold: RspValid=%b ReqReady=%b data=%h expected %b 00 %h",
                         RspValid, ReqReady, RspData, g, sb[0].data);
            end
            @(posedge clk); #1;
        end
        RspReady = 2'b11;
        @(negedge clk);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: empty queue");
        end else begin
            e = sb.pop_front();
            if (RspValid !== e.id || RspData !== e.data ||
                RspErr !== e.err) begin
                fails++;
                $display("FAIL rsp: valid=%b data=%h err=%b expected %b %h %b",
                         RspValid, RspData, RspErr, e.id, e.data, e.err);
            end
        end
        tests++;
        if (ReqReady !== 2'b00) begin
            fails++;
            $display("FAIL accept_cycle: ReqReady=%b expected 00", ReqReady);
        end
        @(posedge clk); #1;
        RspReady = 2'b00;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ReqValid = 2'b11;
        RspReady = 2'b00;
        a0 = 32'd1; b0 = 32'd1; c0 = 4'd0;
        a1 = 32'd2; b1 = 32'd2; c1 = 4'd0;
        tb_last = 1'b1;
        sb.delete();
        #12;
        tests++;
        if (RspValid !== 2'b00 || ReqReady !== 2'b00 ||
            RspData !== 32'h0 || RspErr !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h err=%b expected 00 00 0 0",
                     RspValid, ReqReady, RspData, RspErr);
        end
        tests++;
        if (AluSrcA !== 32'h0 || AluSrcB !== 32'h0 || AluControl !== 4'h0) begin
            fails++;
            $display("FAIL reset_alu: A=%h B=%h C=%h expected 0",
                     AluSrcA, AluSrcB, AluControl);
        end
        ReqValid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_tie;
        a0 = 32'd10; b0 = 32'd4; c0 = 4'b0001;
        a1 = 32'hF0; b1 = 32'h0F; c1 = 4'b0011;
        for (int i = 0; i < 4; i++) run_op(2'b11, 2'b11, 0);
        ReqValid = 2'b00;
    endtask

    task automatic test_single;
        a0 = 32'd5; b0 = 32'd3; c0 = 4'b0001;
        run_op(2'b01, 2'b00, 0);
    endtask

    task automatic test_back_to_back;
        a0 = 32'd7;  b0 = 32'd9;  c0 = 4'b0000;
        a1 = 32'd20; b1 = 32'd5;  c1 = 4'b0001;
        run_op(2'b01, 2'b10, 5);
        run_op(2'b10, 2'b00, 0);
    endtask

    task automatic test_bad_op;
        a0 = 32'd1; b0 = 32'd2; c0 = 4'b0101;
        run_op(2'b01, 2'b00, 0);
        a0 = 32'hFFFF; b0 = 32'h00001234; c0 = 4'b0110;
        run_op(2'b01, 2'b00, 0);
        a1 = 32'h3; b1 = 32'h4; c1 = 4'b0010;
        run_op(2'b10, 2'b00, 1);
    endtask

    task automatic test_reset_in_resp;
        a0 = 32'd11; b0 = 32'd1; c0 = 4'b0000;
        ReqValid = 2'b01;
        @(posedge clk); #1;
        ReqValid = 2'b11;
        @(negedge clk);
        tests++;
        if (RspValid !== 2'b01) begin
            fails++;
            $display("FAIL pre_reset: RspValid=%b expected 01", RspValid);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (RspValid !== 2'b00 || ReqReady !== 2'b00 || AluSrcA !== 32'h0) begin
            fails++;
            $display("FAIL reset_async: valid=%b ready=%b A=%h expected 00 00 0",
                     RspValid, ReqReady, AluSrcA);
        end
        ReqValid = 2'b00;
        @(posedge clk); #1;
        reset = 1'b0;
        tb_last = 1'b1;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (RspValid !== 2'b00) begin
                fails++;
                $display("FAIL post_reset: RspValid=%b expected 00", RspValid);
            end
        end
        @(posedge clk); #1;
        a1 = 32'd9; b1 = 32'd9; c1 = 4'b0000;
        run_op(2'b11, 2'b00, 0);
    endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio;
        a0 = 32'd100; b0 = 32'd1; c0 = 4'b0000;
        a1 = 32'd200; b1 = 32'd1; c1 = 4'b0001;
        for (int i = 0; i < 4; i++) run_op(2'b11, 2'b11, 0);
        ReqValid = 2'b00;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_back_to_back();
        test_bad_op();
        test_reset_in_resp();
`ifdef ALU_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
